// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the three requester ports and the SDRAM controller port handled by sdram_port_arbiter.
// slave: the arbiter's view. master: the requesters plus the controller, as driven by the environment.
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
);
  logic                      req0, req1, req2;
  logic                      we0, we1, we2;
  logic [ADDR_WIDTH-1:0]     addr0, addr1, addr2;
  logic [DATA_WIDTH-1:0]     wdata0, wdata1, wdata2;
  logic [DATA_WIDTH/8-1:0]   bsel0, bsel1, bsel2;
  logic                      ack0, ack1, ack2;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      ctl_req;
  logic                      ctl_we;
  logic [ADDR_WIDTH-1:0]     ctl_addr;
  logic [DATA_WIDTH-1:0]     ctl_wdata;
  logic [DATA_WIDTH/8-1:0]   ctl_bsel;
  logic                      ctl_ack;
  logic [DATA_WIDTH-1:0]     ctl_rdata;
  logic [1:0]                grant;

  modport slave (
    input  req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
           wdata0, wdata1, wdata2, bsel0, bsel1, bsel2, ctl_ack, ctl_rdata,
    output ack0, ack1, ack2, rdata, ctl_req, ctl_we, ctl_addr, ctl_wdata,
           ctl_bsel, grant
  );

  modport master (
    output req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
           wdata0, wdata1, wdata2, bsel0, bsel1, bsel2, ctl_ack, ctl_rdata,
    input  ack0, ack1, ack2, rdata, ctl_req, ctl_we, ctl_addr, ctl_wdata,
           ctl_bsel, grant
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of the single SDRAM controller port; one registered transaction at a time.
// Round-robin by default; define SDRAM_ARB_PRIO_EN for port-0 priority with a starvation guard.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_in,
  sdram_port_arbiter_if.slave  bus
);
  localparam int BW = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] NO_GRANT = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [2:0]            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ctl_req_q, ctl_req_d;
  logic                  ctl_we_q, ctl_we_d;
  logic [ADDR_WIDTH-1:0] ctl_addr_q, ctl_addr_d;
  logic [DATA_WIDTH-1:0] ctl_wdata_q, ctl_wdata_d;
  logic [BW-1:0]         ctl_bsel_q, ctl_bsel_d;

  logic [2:0]            req_s;
  logic [2:0]            elig_s;
  logic [1:0]            win_s;

`ifdef SDRAM_ARB_PRIO_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0]         starve_q, starve_d;
  logic [1:0]            last_low_q, last_low_d;
  logic                  force_low_s;
`endif

  // First set bit of mask in the order last+1, last+2, last+3 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    logic [1:0] p1, p2, p3;
    case (last)
      2'd0:    begin p1 = 2'd1; p2 = 2'd2; p3 = 2'd0; end
      2'd1:    begin p1 = 2'd2; p2 = 2'd0; p3 = 2'd1; end
      default: begin p1 = 2'd0; p2 = 2'd1; p3 = 2'd2; end
    endcase
    if (mask[p1])      rr_pick = p1;
    else if (mask[p2]) rr_pick = p2;
    else               rr_pick = p3;
  endfunction

  // Winner selection and next-state / next-output computation.
  always_comb begin
    req_s  = {bus.req2, bus.req1, bus.req0};
    elig_s = req_s & ~ack_q;
`ifdef SDRAM_ARB_PRIO_EN
    force_low_s = (starve_q == CW'(STARVE_LIMIT)) && (elig_s[1] || elig_s[2]);
    if (force_low_s)    win_s = rr_pick({elig_s[2], elig_s[1], 1'b0}, last_low_q);
    else if (elig_s[0]) win_s = 2'd0;
    else                win_s = rr_pick(elig_s, last_grant_q);
    starve_d   = starve_q;
    last_low_d = last_low_q;
`else
    win_s = rr_pick(elig_s, last_grant_q);
`endif
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    ctl_req_d    = ctl_req_q;
    ctl_we_d     = ctl_we_q;
    ctl_addr_d   = ctl_addr_q;
    ctl_wdata_d  = ctl_wdata_q;
    ctl_bsel_d   = ctl_bsel_q;

    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          state_d   = ST_BUSY;
          ctl_req_d = 1'b1;
          grant_d   = win_s;
          case (win_s)
            2'd0: begin
              ctl_we_d = bus.we0; ctl_addr_d = bus.addr0; ctl_wdata_d = bus.wdata0; ctl_bsel_d = bus.bsel0;
            end
            2'd1: begin
              ctl_we_d = bus.we1; ctl_addr_d = bus.addr1; ctl_wdata_d = bus.wdata1; ctl_bsel_d = bus.bsel1;
            end
            default: begin
              ctl_we_d = bus.we2; ctl_addr_d = bus.addr2; ctl_wdata_d = bus.wdata2; ctl_bsel_d = bus.bsel2;
            end
          endcase
`ifdef SDRAM_ARB_PRIO_EN
          // Only port-0 wins taken over a waiting port count toward starvation.
          if (win_s == 2'd0) begin
            if ((elig_s[1] || elig_s[2]) && (starve_q != CW'(STARVE_LIMIT))) starve_d = starve_q + CW'(1);
            else                                                             starve_d = starve_q;
          end else begin
            starve_d   = '0;
            last_low_d = win_s;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.ctl_ack) begin
          state_d      = ST_ACK;
          ctl_req_d    = 1'b0;
          rdata_d      = bus.ctl_rdata;
          ack_d        = 3'b001 << grant_q;
          last_grant_d = grant_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ack_d   = 3'b000;
        grant_d = NO_GRANT;
      end
      default: begin
        state_d   = ST_IDLE;
        ack_d     = 3'b000;
        grant_d   = NO_GRANT;
        ctl_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      grant_q      <= NO_GRANT;
      last_grant_q <= 2'd2;
      ack_q        <= 3'b000;
      rdata_q      <= '0;
      ctl_req_q    <= 1'b0;
      ctl_we_q     <= 1'b0;
      ctl_addr_q   <= '0;
      ctl_wdata_q  <= '0;
      ctl_bsel_q   <= '0;
`ifdef SDRAM_ARB_PRIO_EN
      starve_q     <= '0;
      last_low_q   <= 2'd2;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      ctl_req_q    <= ctl_req_d;
      ctl_we_q     <= ctl_we_d;
      ctl_addr_q   <= ctl_addr_d;
      ctl_wdata_q  <= ctl_wdata_d;
      ctl_bsel_q   <= ctl_bsel_d;
`ifdef SDRAM_ARB_PRIO_EN
      starve_q     <= starve_d;
      last_low_q   <= last_low_d;
`endif
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.ack2      = ack_q[2];
  assign bus.rdata     = rdata_q;
  assign bus.ctl_req   = ctl_req_q;
  assign bus.ctl_we    = ctl_we_q;
  assign bus.ctl_addr  = ctl_addr_q;
  assign bus.ctl_wdata = ctl_wdata_q;
  assign bus.ctl_bsel  = ctl_bsel_q;
  assign bus.grant     = grant_q;
endmodule
